// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants and helper macros for the register file / scoreboard slice.
//   ZERO_WORD(w)  : all-zero word of width w
//   WORD_WIDTH(w) : register width in bits
//   REG_SIZE(a)   : number of architectural registers for an index width a
`ifndef REGFILE_SCOREBOARD_DEFINES
`define REGFILE_SCOREBOARD_DEFINES
`define ZERO_WORD(w) {(w){1'b0}}
`define WORD_WIDTH(w) (w)
`define REG_SIZE(a) (2 ** (a))
`endif

package regfile_scoreboard_pkg;

    localparam int unsigned DefaultDataWidth = 32;
    localparam int unsigned DefaultAddrWidth = 5;
    localparam int unsigned DefaultNumRd     = 2;
    localparam int unsigned DefaultNumWr     = 2;

    // Architectural zero register: reads as zero, never stored, never busy.
    localparam int unsigned RegZero = 0;

endpackage

// File: rtl/regfile_wr_select.sv
// Write-port selector: for one query address, reports whether any enabled write
// port targets it and returns the data of the highest-index such port.
// Ports:
//   wr_en     [NUM_WR]             per-port write enable
//   wr_addr   [NUM_WR*ADDR_WIDTH]  packed write indices
//   wr_data   [NUM_WR*DATA_WIDTH]  packed write data
//   queryAddr [ADDR_WIDTH]         address being looked up
//   hit                            some enabled port targets queryAddr
//   data      [DATA_WIDTH]         winning port's data (zero when no hit)
module regfile_wr_select
    import regfile_scoreboard_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth,
    parameter int unsigned ADDR_WIDTH = DefaultAddrWidth,
    parameter int unsigned NUM_WR     = DefaultNumWr
) (
    input  logic [NUM_WR-1:0]            wr_en,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0]        queryAddr,
    output logic                         hit,
    output logic [DATA_WIDTH-1:0]        data
);

    // Ascending scan: a later (higher-index) match overrides earlier ones.
    always_comb begin
        hit  = 1'b0;
        data = `ZERO_WORD(DATA_WIDTH);
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && (wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == queryAddr)) begin
                hit  = 1'b1;
                data = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with same-cycle write bypass and a per-register busy
// scoreboard. Decode reads operands and reserves destinations; writeback writes
// results and releases them; flush clears all reservations.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   rd_addr     packed read indices           rd_data   packed read data (comb.)
//   rd_ready    per-port operand valid
//   wr_en       per-port write enable         wr_addr / wr_data  packed write ports
//   alloc_en    reserve alloc_addr            flush     clear all busy bits
//   busy_vec    registered scoreboard
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth,
    parameter int unsigned ADDR_WIDTH = DefaultAddrWidth,
    parameter int unsigned NUM_RD     = DefaultNumRd,
    parameter int unsigned NUM_WR     = DefaultNumWr
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]           rd_addr,
    output logic [NUM_RD*`WORD_WIDTH(DATA_WIDTH)-1:0] rd_data,
    output logic [NUM_RD-1:0]                      rd_ready,
    input  logic [NUM_WR-1:0]                      wr_en,
    input  logic [NUM_WR*ADDR_WIDTH-1:0]           wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0]           wr_data,
    input  logic                                   alloc_en,
    input  logic [ADDR_WIDTH-1:0]                  alloc_addr,
    input  logic                                   flush,
    output logic [`REG_SIZE(ADDR_WIDTH)-1:0]       busy_vec
);

    localparam int unsigned NumRegs = `REG_SIZE(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ZeroAddr = ADDR_WIDTH'(RegZero);

    logic [DATA_WIDTH-1:0] regsQ [NumRegs];
    logic [NumRegs-1:0]    busyQ, busyD;

    logic [NumRegs-1:0]    commitHit;
    logic [DATA_WIDTH-1:0] commitData [NumRegs];

    // Per-register commit selection; register 0 never commits.
    for (genvar r = 0; r < NumRegs; r++) begin : gCommit
        if (r == RegZero) begin : gZero
            assign commitHit[r]  = 1'b0;
            assign commitData[r] = `ZERO_WORD(DATA_WIDTH);
        end else begin : gSel
            regfile_wr_select #(
                .DATA_WIDTH (DATA_WIDTH),
                .ADDR_WIDTH (ADDR_WIDTH),
                .NUM_WR     (NUM_WR)
            ) uSel (
                .wr_en     (wr_en),
                .wr_addr   (wr_addr),
                .wr_data   (wr_data),
                .queryAddr (ADDR_WIDTH'(r)),
                .hit       (commitHit[r]),
                .data      (commitData[r])
            );
        end
    end

    // Read ports with same-cycle bypass from the write ports.
    for (genvar p = 0; p < NUM_RD; p++) begin : gRead
        logic [ADDR_WIDTH-1:0] addr;
        logic                  bypHit;
        logic [DATA_WIDTH-1:0] bypData;

        assign addr = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];

        regfile_wr_select #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .NUM_WR     (NUM_WR)
        ) uSel (
            .wr_en     (wr_en),
            .wr_addr   (wr_addr),
            .wr_data   (wr_data),
            .queryAddr (addr),
            .hit       (bypHit),
            .data      (bypData)
        );

        assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] =
            (addr == ZeroAddr) ? `ZERO_WORD(DATA_WIDTH) :
            bypHit             ? bypData : regsQ[addr];
        assign rd_ready[p] = (addr == ZeroAddr) || !busyQ[addr] || bypHit;
    end

    // Scoreboard next state: flush beats everything; alloc beats a same-cycle
    // release because it represents a new producer already in flight.
    always_comb begin
        busyD = busyQ;
        if (flush) begin
            busyD = '0;
        end else begin
            busyD = busyQ & ~commitHit;
            if (alloc_en && (alloc_addr != ZeroAddr)) begin
                busyD[alloc_addr] = 1'b1;
            end
        end
        busyD[RegZero] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NumRegs; r++) begin
                regsQ[r] <= `ZERO_WORD(DATA_WIDTH);
            end
            busyQ <= '0;
        end else begin
            for (int r = 0; r < NumRegs; r++) begin
                if (commitHit[r]) begin
                    regsQ[r] <= commitData[r];
                end
            end
            busyQ <= busyD;
        end
    end

    assign busy_vec = busyQ;

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int NREGS = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR*AW-1:0]  rdAddr;
    logic [NR*DW-1:0]  rdData;
    logic [NR-1:0]     rdReady;
    logic [NW-1:0]     wrEn;
    logic [NW*AW-1:0]  wrAddr;
    logic [NW*DW-1:0]  wrData;
    logic              allocEn;
    logic [AW-1:0]     allocAddr;
    logic              flush;
    logic [NREGS-1:0]  busyVec;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [DW-1:0] mReg [NREGS];
    logic          mBusy [NREGS];

    regfile_scoreboard #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_RD     (NR),
        .NUM_WR     (NW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr    (rdAddr),
        .rd_data    (rdData),
        .rd_ready   (rdReady),
        .wr_en      (wrEn),
        .wr_addr    (wrAddr),
        .wr_data    (wrData),
        .alloc_en   (allocEn),
        .alloc_addr (allocAddr),
        .flush      (flush),
        .busy_vec   (busyVec)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int wAddr(input int w);
        logic [NW*AW-1:0] v;
        v = wrAddr;
        return int'(v[w*AW +: AW]);
    endfunction

    function automatic logic [DW-1:0] wData(input int w);
        logic [NW*DW-1:0] v;
        v = wrData;
        return v[w*DW +: DW];
    endfunction

    task automatic idle();
        rst = 1'b0; wrEn = '0; wrAddr = '0; wrData = '0;
        allocEn = 1'b0; allocAddr = '0; flush = 1'b0;
    endtask

    task automatic setWr(input int w, input int a, input logic [DW-1:0] d);
        wrEn[w] = 1'b1;
        wrAddr[w*AW +: AW] = AW'(a);
        wrData[w*DW +: DW] = d;
    endtask

    task automatic setRd(input int p, input int a);
        rdAddr[p*AW +: AW] = AW'(a);
    endtask

    function automatic logic [63:0] busyModel();
        logic [63:0] v;
        v = '0;
        for (int r = 0; r < NREGS; r++) v[r] = mBusy[r];
        return v;
    endfunction

    // Let inputs settle, then compare combinational read outputs with the model.
    task automatic settle();
        #1;
        for (int p = 0; p < NR; p++) begin
            int a;
            logic [DW-1:0] expData;
            logic expReady;
            logic hit;
            logic [NR*AW-1:0] ra;
            logic [NR*DW-1:0] rdv;
            ra = rdAddr;
            rdv = rdData;
            a = int'(ra[p*AW +: AW]);
            hit = 1'b0;
            expData = mReg[a];
            for (int w = NW - 1; w >= 0; w--) begin
                if (!hit && wrEn[w] && wAddr(w) == a) begin
                    hit = 1'b1;
                    expData = wData(w);
                end
            end
            if (a == 0) expData = '0;
            expReady = (a == 0) || !mBusy[a] || hit;
            checkEq($sformatf("rd_data[%0d] a=%0d", p, a), 64'(rdv[p*DW +: DW]), 64'(expData));
            checkEq($sformatf("rd_ready[%0d] a=%0d", p, a), 64'(rdReady[p]), 64'(expReady));
        end
    endtask

    // Clock edge with model update from the held inputs, then scoreboard compare.
    task automatic advance();
        logic [DW-1:0] nReg [NREGS];
        logic          nBusy [NREGS];
        for (int r = 0; r < NREGS; r++) begin
            nReg[r] = mReg[r];
            nBusy[r] = mBusy[r];
        end
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                nReg[r] = '0;
                nBusy[r] = 1'b0;
            end
        end else begin
            for (int w = 0; w < NW; w++) begin
                if (wrEn[w] && wAddr(w) != 0) begin
                    nReg[wAddr(w)] = wData(w);
                    nBusy[wAddr(w)] = 1'b0;
                end
            end
            if (flush) begin
                for (int r = 0; r < NREGS; r++) nBusy[r] = 1'b0;
            end else if (allocEn && allocAddr != 0) begin
                nBusy[allocAddr] = 1'b1;
            end
        end
        @(posedge clk);
        for (int r = 0; r < NREGS; r++) begin
            mReg[r] = nReg[r];
            mBusy[r] = nBusy[r];
        end
        #1;
        checkEq("busy_vec", 64'(busyVec), busyModel());
    endtask

    initial begin
        for (int r = 0; r < NREGS; r++) begin
            mReg[r] = '0;
            mBusy[r] = 1'b0;
        end
        idle();
        rdAddr = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        advance();

        // Reset clears a written register
        idle();
        setWr(0, 5, 32'hDEAD);
        settle();
        advance();
        idle();
        rst = 1'b1;
        advance();
        idle();
        setRd(0, 5);
        settle();
        checkEq("reset r5", 64'(rdData[DW-1:0]), 64'h0);
        checkEq("reset ready", 64'(rdReady), 64'h3);
        checkEq("reset busy", 64'(busyVec), 64'h0);

        // Write-port priority
        setWr(0, 3, 32'h11);
        setWr(1, 3, 32'h22);
        setRd(0, 3);
        settle();
        checkEq("prio bypass", 64'(rdData[DW-1:0]), 64'h22);
        advance();
        idle();
        settle();
        checkEq("prio commit", 64'(rdData[DW-1:0]), 64'h22);

        // Bypass clears the not-ready condition
        allocEn = 1'b1; allocAddr = 5'd7;
        advance();
        idle();
        setRd(0, 7);
        settle();
        checkEq("r7 busy ready", 64'(rdReady[0]), 64'h0);
        setWr(0, 7, 32'hABCD);
        settle();
        checkEq("r7 byp ready", 64'(rdReady[0]), 64'h1);
        checkEq("r7 byp data", 64'(rdData[DW-1:0]), 64'hABCD);
        advance();
        idle();
        checkEq("r7 released", 64'(busyVec[7]), 64'h0);

        // Alloc wins over release of the same register
        allocEn = 1'b1; allocAddr = 5'd9;
        advance();
        setWr(1, 9, 32'h5);
        advance();
        idle();
        setRd(0, 9);
        settle();
        checkEq("r9 data", 64'(rdData[DW-1:0]), 64'h5);
        checkEq("r9 busy", 64'(busyVec[9]), 64'h1);

        // Flush clears everything, drops alloc, still commits data
        allocEn = 1'b1; allocAddr = 5'd4;
        advance();
        allocAddr = 5'd6;
        advance();
        idle();
        flush = 1'b1; allocEn = 1'b1; allocAddr = 5'd8;
        setWr(0, 4, 32'h77);
        advance();
        idle();
        checkEq("flush busy", 64'(busyVec), 64'h0);
        setRd(0, 4);
        settle();
        checkEq("flush r4", 64'(rdData[DW-1:0]), 64'h77);

        // Zero register
        setWr(0, 0, 32'hFFFF_FFFF);
        allocEn = 1'b1; allocAddr = 5'd0;
        setRd(0, 0);
        setRd(1, 0);
        settle();
        checkEq("r0 byp", 64'(rdData), 64'h0);
        advance();
        idle();
        settle();
        checkEq("r0 data", 64'(rdData[DW-1:0]), 64'h0);
        checkEq("r0 ready", 64'(rdReady[0]), 64'h1);
        checkEq("r0 busy", 64'(busyVec[0]), 64'h0);

        // Randomized traffic on a narrow address range to force collisions
        for (int i = 0; i < 400; i++) begin
            idle();
            rst = ($urandom_range(0, 63) == 0);
            flush = ($urandom_range(0, 15) == 0);
            allocEn = $urandom_range(0, 1) == 1;
            allocAddr = AW'($urandom_range(0, 11));
            for (int w = 0; w < NW; w++) begin
                if ($urandom_range(0, 2) != 0) setWr(w, $urandom_range(0, 11), $urandom());
            end
            for (int p = 0; p < NR; p++) setRd(p, $urandom_range(0, 11));
            settle();
            advance();
        end

        idle();
        settle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
